// File: rtl/ysyx_25030093_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25030093_fetch_decode
// Purpose  : Multi-cycle instruction fetch / decode front end. It holds the
//            PC, issues one word fetch at a time to instruction memory,
//            decodes ADDI and EBREAK and hands one decoded command at a time
//            to the EXU. Unsupported encodings and EBREAK stop the front end
//            until reset.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            imem_req_valid/ready - fetch request handshake
//            imem_addr            - fetch address (current PC)
//            imem_rsp_valid/data  - fetch response (single-cycle pulse)
//            exu_valid/ready      - decoded command handshake
//            imm_data, rd, rs1,
//            Regwrite, pc_out     - decoded command fields
//            ebreak, illegal      - classification of the issued command
//            halted               - front end stopped
//            inst_cnt             - issued-instruction counter (optional)
// Options  : define YSYX_25030093_INST_CNT_EN to add the inst_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25030093_fetch_decode #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          XLEN     = 32
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            exu_valid,
   input  logic            exu_ready,
   output logic [XLEN-1:0] imm_data,
   output logic [4:0]      rd,
   output logic [4:0]      rs1,
   output logic            Regwrite,
   output logic [XLEN-1:0] pc_out,
   output logic            ebreak,
   output logic            illegal,
`ifdef YSYX_25030093_INST_CNT_EN
   output logic [31:0]     inst_cnt,
`endif
   output logic            halted
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      ISSUE = 2'd2,
      HALT  = 2'd3
   } state_t;

   localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
   localparam logic [6:0]  OP_IMM      = 7'b0010011;
   localparam logic [2:0]  F3_ADDI     = 3'b000;

   state_t          state;
   logic [XLEN-1:0] pc;

   // Decode of the incoming response word; only sampled into the output
   // registers in WAIT, so the EXU never sees a combinational path from
   // imem_rsp_data.
   logic [XLEN-1:0] dec_imm;
   logic [4:0]      dec_rd;
   logic [4:0]      dec_rs1;
   logic            dec_regwrite;
   logic            dec_ebreak;
   logic            dec_illegal;

   always_comb begin
      dec_rd       = imem_rsp_data[11:7];
      dec_rs1      = imem_rsp_data[19:15];
      dec_imm      = {{20{imem_rsp_data[31]}}, imem_rsp_data[31:20]};
      dec_regwrite = 1'b0;
      dec_ebreak   = 1'b0;
      dec_illegal  = 1'b0;
      if (imem_rsp_data[6:0] == OP_IMM && imem_rsp_data[14:12] == F3_ADDI) begin
         dec_regwrite = (imem_rsp_data[11:7] != 5'd0);
      end else if (imem_rsp_data == EBREAK_INST) begin
         dec_ebreak = 1'b1;
         dec_imm    = '0;
      end else begin
         dec_illegal = 1'b1;
      end
   end

   assign imem_addr = pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= FETCH;
         pc             <= RESET_PC;
         imem_req_valid <= 1'b0;
         exu_valid      <= 1'b0;
         imm_data       <= '0;
         rd             <= '0;
         rs1            <= '0;
         Regwrite       <= 1'b0;
         pc_out         <= '0;
         ebreak         <= 1'b0;
         illegal        <= 1'b0;
         halted         <= 1'b0;
`ifdef YSYX_25030093_INST_CNT_EN
         inst_cnt       <= '0;
`endif
      end else begin
         case (state)
            // The request is raised one cycle after entering FETCH, so it is
            // never asserted in the reset cycle nor in the ISSUE handshake
            // cycle; once raised it stays up until accepted.
            FETCH: begin
               if (imem_req_valid && imem_req_ready) begin
                  imem_req_valid <= 1'b0;
                  state          <= WAIT;
               end else begin
                  imem_req_valid <= 1'b1;
               end
            end
            WAIT: begin
               if (imem_rsp_valid) begin
                  exu_valid <= 1'b1;
                  imm_data  <= dec_imm;
                  rd        <= dec_rd;
                  rs1       <= dec_rs1;
                  Regwrite  <= dec_regwrite;
                  ebreak    <= dec_ebreak;
                  illegal   <= dec_illegal;
                  pc_out    <= pc;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (exu_ready) begin
                  exu_valid <= 1'b0;
`ifdef YSYX_25030093_INST_CNT_EN
                  inst_cnt  <= inst_cnt + 32'd1;
`endif
                  // A stopping instruction leaves the PC pointing at itself.
                  if (ebreak || illegal) begin
                     halted <= 1'b1;
                     state  <= HALT;
                  end else begin
                     pc    <= pc + 32'd4;
                     state <= FETCH;
                  end
               end
            end
            HALT: begin
               state <= HALT;
            end
            default: begin
               state <= FETCH;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25030093_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_25030093_fetch_decode
// Purpose  : Directed self-checking bench for ysyx_25030093_fetch_decode.
//            Expected decode results are queued when a response is driven
//            and popped when the front end presents a command to the EXU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_25030093_fetch_decode;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        exu_valid;
   logic        exu_ready;
   logic [31:0] imm_data;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic        Regwrite;
   logic [31:0] pc_out;
   logic        ebreak;
   logic        illegal;
   logic        halted;
`ifdef YSYX_25030093_INST_CNT_EN
   logic [31:0] inst_cnt;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic        regw;
      logic [31:0] pc;
      logic        ebreak;
      logic        illegal;
   } exp_t;

   exp_t sb[$];
   exp_t cur;

   ysyx_25030093_fetch_decode #(
      .RESET_PC (32'h8000_0000),
      .XLEN     (32)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .exu_valid      (exu_valid),
      .exu_ready      (exu_ready),
      .imm_data       (imm_data),
      .rd             (rd),
      .rs1            (rs1),
      .Regwrite       (Regwrite),
      .pc_out         (pc_out),
      .ebreak         (ebreak),
      .illegal        (illegal),
`ifdef YSYX_25030093_INST_CNT_EN
      .inst_cnt       (inst_cnt),
`endif
      .halted         (halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_cmd(input string tag, input exp_t e);
      chk({tag, "_exu_valid"}, {31'd0, exu_valid}, 32'd1);
      chk({tag, "_imm"},       imm_data,           e.imm);
      chk({tag, "_rd"},        {27'd0, rd},        {27'd0, e.rd});
      chk({tag, "_rs1"},       {27'd0, rs1},       {27'd0, e.rs1});
      chk({tag, "_regwrite"},  {31'd0, Regwrite},  {31'd0, e.regw});
      chk({tag, "_pc_out"},    pc_out,             e.pc);
      chk({tag, "_ebreak"},    {31'd0, ebreak},    {31'd0, e.ebreak});
      chk({tag, "_illegal"},   {31'd0, illegal},   {31'd0, e.illegal});
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
      chk({tag, "_exu_valid"}, {31'd0, exu_valid},      32'd0);
      chk({tag, "_imm"},       imm_data,                32'd0);
      chk({tag, "_rd_rs1"},    {22'd0, rd, rs1},        32'd0);
      chk({tag, "_flags"},     {28'd0, Regwrite, ebreak, illegal, halted}, 32'd0);
      chk({tag, "_pc_out"},    pc_out,                  32'd0);
      chk({tag, "_imem_addr"}, imem_addr,               32'h8000_0000);
`ifdef YSYX_25030093_INST_CNT_EN
      chk({tag, "_inst_cnt"},  inst_cnt,                32'd0);
`endif
   endtask

   // Entered and left on a falling edge. Waits (bounded) for the request,
   // optionally stalls it, then accepts it.
   task automatic do_fetch(input logic [31:0] exp_addr, input int delay);
      logic found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (imem_req_valid) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("req_seen", {31'd0, found}, 32'd1);
      chk("imem_addr", imem_addr, exp_addr);
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         chk("req_stall_valid", {31'd0, imem_req_valid}, 32'd1);
         chk("req_stall_addr", imem_addr, exp_addr);
      end
      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
      chk("req_drop_in_wait", {31'd0, imem_req_valid}, 32'd0);
   endtask

   // Drives a one-cycle response in WAIT and checks the command that
   // appears the following cycle against the scoreboard head.
   task automatic respond(input logic [31:0] inst, input exp_t e);
      sb.push_back(e);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = inst;
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      chk("sb_nonempty", sb.size(), 32'd1);
      if (sb.size() != 0) begin
         cur = sb.pop_front();
         chk_cmd("decode", cur);
      end
   endtask

   task automatic issue(input int hold);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk_cmd("hold", cur);
      end
      exu_ready = 1'b1;
      @(negedge clk);
      exu_ready = 1'b0;
      chk("exu_valid_drop", {31'd0, exu_valid}, 32'd0);
   endtask

   function automatic exp_t mk(input logic [31:0] imm, input logic [4:0] r_d,
                               input logic [4:0] r_s1, input logic rw,
                               input logic [31:0] pc, input logic eb,
                               input logic il);
      exp_t e;
      e.imm = imm; e.rd = r_d; e.rs1 = r_s1; e.regw = rw;
      e.pc = pc; e.ebreak = eb; e.illegal = il;
      return e;
   endfunction

   initial begin
      rst            = 1'b1;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      exu_ready      = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // addi x1,x0,5
      do_fetch(32'h8000_0000, 0);
      respond(32'h0050_0093, mk(32'd5, 5'd1, 5'd0, 1'b1, 32'h8000_0000, 1'b0, 1'b0));
      issue(0);

      // addi x2,x1,-1 with EXU back-pressure
      do_fetch(32'h8000_0004, 0);
      respond(32'hFFF0_8113, mk(32'hFFFF_FFFF, 5'd2, 5'd1, 1'b1, 32'h8000_0004, 1'b0, 1'b0));
      issue(5);

      // addi x0,x0,0 with memory back-pressure
      do_fetch(32'h8000_0008, 3);
      respond(32'h0000_0013, mk(32'd0, 5'd0, 5'd0, 1'b0, 32'h8000_0008, 1'b0, 1'b0));
      issue(0);

      // ebreak: stop and stay stopped
      do_fetch(32'h8000_000C, 0);
      respond(32'h0010_0073, mk(32'd0, 5'd0, 5'd0, 1'b0, 32'h8000_000C, 1'b1, 1'b0));
      issue(1);
      chk("halted_after_ebreak", {31'd0, halted}, 32'd1);
`ifdef YSYX_25030093_INST_CNT_EN
      chk("inst_cnt_4", inst_cnt, 32'd4);
`endif
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("halt_no_req", {30'd0, imem_req_valid, exu_valid}, 32'd0);
      end
      chk("halt_sticky", {31'd0, halted}, 32'd1);

      // reset during HALT, then an unsupported encoding (add)
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk_reset_outputs("reset_halt");
      rst = 1'b0;
      @(negedge clk);
      do_fetch(32'h8000_0000, 0);
      respond(32'h0000_0033, mk(32'd0, 5'd0, 5'd0, 1'b0, 32'h8000_0000, 1'b0, 1'b1));
      issue(0);
      chk("halted_after_illegal", {31'd0, halted}, 32'd1);
      repeat (3) @(negedge clk);
      chk("illegal_no_req", {31'd0, imem_req_valid}, 32'd0);

      // reset in HALT, fetch, then reset while the response is still owed
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      do_fetch(32'h8000_0000, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk_reset_outputs("reset_wait");
      rst = 1'b0;
      // late response from the aborted fetch arrives while in FETCH
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0050_0093;
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("stale_rsp_ignored", {31'd0, exu_valid}, 32'd0);
      do_fetch(32'h8000_0000, 0);
      respond(32'h0070_0193, mk(32'd7, 5'd3, 5'd0, 1'b1, 32'h8000_0000, 1'b0, 1'b0));
      issue(0);
      do_fetch(32'h8000_0004, 0);

      chk("sb_drained", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ysyx_25030093_fetch_decode.md
Name: ysyx_25030093_fetch_decode

Overview:
Instruction fetch and decode front end that produces the execute-stage command (imm_data, rd, rs1, Regwrite) consumed by the EXU. It holds the PC and issues word fetches to instruction memory over a valid/ready request and a valid response. It decodes ADDI and EBREAK and hands one decoded instruction at a time to the EXU over a valid/ready handshake. It is a multi-cycle, non-pipelined design with at most one fetch outstanding.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset.
XLEN, 32, data/address width; only 32 is supported.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
imem_req_valid  out  1  fetch request valid.
imem_req_ready  in  1  memory accepts the request.
imem_addr  out  32  fetch address; equals the current PC.
imem_rsp_valid  in  1  fetch data valid, one-cycle pulse.
imem_rsp_data  in  32  fetched instruction word.
exu_valid  out  1  decoded instruction valid.
exu_ready  in  1  EXU accepts the instruction.
imm_data  out  32  sign-extended I-type immediate.
rd  out  5  destination register index, inst[11:7].
rs1  out  5  source register index, inst[19:15].
Regwrite  out  1  register write enable for the EXU.
pc_out  out  32  PC of the issued instruction.
ebreak  out  1  issued instruction is EBREAK.
illegal  out  1  issued instruction is not supported.
halted  out  1  front end has stopped.

Behaviour:
- FSM states: FETCH, WAIT, ISSUE, HALT. Reset state is FETCH.
- Reset values: pc=RESET_PC; imem_req_valid=0 in the reset cycle. All EXU outputs are 0, including exu_valid, imm_data, rd, rs1, Regwrite, pc_out, ebreak, illegal and halted.
- FETCH: drive imem_req_valid=1 and imem_addr=pc. Hold both stable until imem_req_ready=1. On handshake, go to WAIT.
- WAIT: imem_req_valid=0. On imem_rsp_valid, latch the decode results into the output registers and go to ISSUE.
- Response timing: the response arrives no earlier than the cycle after request acceptance. imem_rsp_valid is ignored in every state except WAIT.
- Decode latency: exu_valid rises the cycle after imem_rsp_valid. Outputs are registered, with no combinational path from imem_rsp_data.
- ADDI (opcode 7'b0010011, funct3 3'b000):
  - imm_data = {{20{inst[31]}}, inst[31:20]}
  - Regwrite = (rd != 0)
  - ebreak = 0, illegal = 0
- EBREAK (inst == 32'h0010_0073): Regwrite=0, ebreak=1, imm_data=0.
- Any other encoding: illegal=1, Regwrite=0. rd, rs1 and imm_data carry the raw fields.
- ISSUE: hold exu_valid=1 and every EXU output stable until exu_ready=1.
- On the ISSUE handshake:
  - ADDI: pc <= pc+4 (32-bit wrap, 32'hFFFF_FFFC+4 gives 0). exu_valid drops the next cycle. Next state is FETCH.
  - EBREAK or illegal: go to HALT. pc is not incremented.
- HALT: exu_valid=0, imem_req_valid=0, halted=1. The FSM stays in HALT until rst.
- The next fetch request is asserted no earlier than the cycle after the ISSUE handshake.
- Reset mid-operation applies in any state:
  - Go to FETCH with pc=RESET_PC and clear all outputs.
  - A response still owed from the aborted fetch is dropped, because imem_rsp_valid is ignored outside WAIT. Memory must not return a stale response after reset release into the new WAIT; this is a system-level constraint.
- exu_ready while exu_valid=0 has no effect.

Optional Feature:
YSYX_25030093_INST_CNT_EN.
- Defined: adds output port inst_cnt [31:0].
  - Reset value 0.
  - Increments by 1 on every ISSUE handshake, including EBREAK and illegal.
  - Wraps from 32'hFFFF_FFFF to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then imem_req_ready=1 → imem_addr=32'h8000_0000 with imem_req_valid=1. After rsp 32'h0050_0093 (addi x1,x0,5): exu_valid, imm_data=5, rd=1, rs1=0, Regwrite=1, pc_out=32'h8000_0000. After exu_ready=1, the next imem_addr is 32'h8000_0004.
- Rsp 32'hFFF0_8113 (addi x2,x1,-1) with exu_ready held 0 for 5 cycles → outputs stay stable; imm_data=32'hFFFF_FFFF, rd=2, rs1=1.
- addi x0,x0,0 (32'h0000_0013) → Regwrite=0, illegal=0. imem_req_ready low for 3 cycles → imem_addr held stable for all 3 cycles.
- Rsp 32'h0010_0073 → ebreak=1, Regwrite=0. After the handshake: halted=1 and no further imem_req_valid over 20 cycles.
- Rsp 32'h0000_0033 (add) → illegal=1, halted after the handshake. Then assert rst during HALT, and again during WAIT with a late rsp pulse → pc=32'h8000_0000, the stale rsp is ignored, and fetch restarts.
- With YSYX_25030093_INST_CNT_EN defined, 3 ADDIs then EBREAK → inst_cnt=4. Reset → inst_cnt=0.
